// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_pkg;

   localparam int RF_WIDTH_DEF = 4;
   localparam int RF_DEPTH_DEF = 4;

   // DEPTH need not be a power of two, so some encodable addresses have no entry.
   function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
      return (addr >= depth);
   endfunction

endpackage

// File: rtl/regfile_entry.sv
// One storage word plus its valid flag; clear wins over load.
module regfile_entry
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             valid_q;
   logic             valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr_i) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (load_i) begin
         data_d  = d_i;
         valid_d = 1'b1;
      end else begin
         data_d  = data_q;
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q_o     = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/regfile_nport.sv
// Two-read/one-write register file with valid flags, synchronous clear,
// optional write-to-read bypass, optional registered reads and bad-write flag.
module regfile_nport
   import regfile_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH_DEF,
   parameter int DEPTH    = RF_DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter bit BYPASS   = 1'b1,
   parameter bit REG_READ = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              W,
   input  logic [ADDR_W-1:0] DA,
   input  logic [WIDTH-1:0]  D,
   input  logic [ADDR_W-1:0] SA,
   input  logic [ADDR_W-1:0] SB,
   output logic [WIDTH-1:0]  A,
   output logic [WIDTH-1:0]  B,
   output logic              valid_a,
   output logic              valid_b,
   output logic              wr_err
);

   logic [WIDTH-1:0] data_s [DEPTH];
   logic             vld_s  [DEPTH];
   logic             wr_ok_s;
   logic             wr_err_d;
   logic             wr_err_q;
   logic [WIDTH-1:0] rd_a_s;
   logic [WIDTH-1:0] rd_b_s;
   logic             rd_va_s;
   logic             rd_vb_s;

   assign wr_ok_s  = W & ~clr & ~addr_oor(32'(DA), 32'(DEPTH));
   assign wr_err_d = W & ~clr &  addr_oor(32'(DA), 32'(DEPTH));

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      regfile_entry #(.WIDTH(WIDTH)) u_entry (
         .clk_i   (clk),
         .rst_ni  (rst),
         .clr_i   (clr),
         .load_i  (wr_ok_s && (DA == ADDR_W'(i))),
         .d_i     (D),
         .q_o     (data_s[i]),
         .valid_o (vld_s[i])
      );
   end

   // Returns {valid, data} for one read port, forwarding an accepted write if enabled.
   function automatic logic [WIDTH:0] read_port(input logic [ADDR_W-1:0] sel);
      logic [WIDTH:0] r;
      r = '0;
      if (addr_oor(32'(sel), 32'(DEPTH))) begin
         r = '0;
      end else if (BYPASS && wr_ok_s && (DA == sel)) begin
         r = {1'b1, D};
      end else begin
         r = {vld_s[sel], data_s[sel]};
      end
      return r;
   endfunction

   always_comb begin
      {rd_va_s, rd_a_s} = read_port(SA);
      {rd_vb_s, rd_b_s} = read_port(SB);
   end

   if (REG_READ) begin : g_reg_read
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             va_q;
      logic             vb_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            va_q <= 1'b0;
            vb_q <= 1'b0;
         end else if (clr) begin
            a_q  <= '0;
            b_q  <= '0;
            va_q <= 1'b0;
            vb_q <= 1'b0;
         end else begin
            a_q  <= rd_a_s;
            b_q  <= rd_b_s;
            va_q <= rd_va_s;
            vb_q <= rd_vb_s;
         end
      end

      assign A       = a_q;
      assign B       = b_q;
      assign valid_a = va_q;
      assign valid_b = vb_q;
   end else begin : g_comb_read
      assign A       = rd_a_s;
      assign B       = rd_b_s;
      assign valid_a = rd_va_s;
      assign valid_b = rd_vb_s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_err = wr_err_q;

endmodule

// File: doc/regfile_nport.md
# regfile_nport

Parametrised two-read/one-write register file for the datapath. It replaces the fixed two-entry, 4-bit register file, and generalises depth and width. It also adds:
- per-entry valid flags
- a synchronous clear
- optional write-to-read bypass
- optional registered read ports
- out-of-range write detection

It sits between the ROM/ALU result bus (write side) and the ALU operand inputs (read side).

## Interface
Parameters:
- WIDTH, 4, data width of each entry
- DEPTH, 4, number of entries (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
- REG_READ, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all entries and valid flags
- W  in  1  write enable
- DA  in  ADDR_W  destination address
- D  in  WIDTH  write data
- SA  in  ADDR_W  read address, port A
- SB  in  ADDR_W  read address, port B
- A  out  WIDTH  read data, port A
- B  out  WIDTH  read data, port B
- valid_a  out  1  entry at SA has been written since last reset/clear
- valid_b  out  1  same, for SB
- wr_err  out  1  registered one-cycle pulse: write attempted to DA ≥ DEPTH

## Operation
- Storage: DEPTH entries of WIDTH bits, each with a valid bit.
- Accepted write: W=1, clr=0 and DA<DEPTH. On the clk edge, entry[DA]←D and valid[DA]←1. All other entries hold.
- clr=1: on the clk edge, all entries←0 and all valid←0. clr has priority over W; a simultaneous write is dropped and does not raise wr_err.
- Out-of-range write: W=1, clr=0, DA≥DEPTH. Storage is unchanged and wr_err=1 for the following cycle. Back-to-back bad writes hold wr_err high.
- Read, SA/SB<DEPTH: return the entry and its valid bit.
- Read, SA/SB≥DEPTH: return 0 with valid=0.
- Bypass (BYPASS=1): if a write is accepted this cycle and DA==SA, the port sees D with valid=1 instead of stored data. Port B behaves the same with SB. Both ports may bypass at once.
- BYPASS=0: reads return pre-edge storage.
- Reading the same address on both ports is legal; A and B are identical.
- REG_READ=1: A/B/valid_a/valid_b are captured on the clk edge from the combinational read value (bypass included if enabled). They therefore reflect the written value one cycle after the write. While clr is asserted, the captured value is 0/valid=0.

## Timing
- Asynchronous reset (rst=0): all entries 0, all valid 0, wr_err 0. If REG_READ=1, A/B/valid_a/valid_b are also 0.
  - With REG_READ=0, the outputs read 0/valid 0 immediately through storage.
- Reset release takes effect at the first clk edge with rst=1.
- Write latency: 1 cycle, i.e. data is visible from storage after the edge.
- Bypass latency: 0 cycles (REG_READ=0) or 1 cycle (REG_READ=1).
- Read latency: combinational (REG_READ=0) or 1 cycle (REG_READ=1).
- rst asserted mid-write: the write is lost and the entry reads 0.

## Structure
- Shared package regfile_pkg: the out-of-range address compare helper and the default WIDTH/DEPTH constants.
- Sub-module regfile_entry: one WIDTH-bit register plus valid bit, with load, clr and asynchronous active-low rst. It is instantiated DEPTH times via generate.
- Write decode, read mux, bypass and optional output register live in the top level.

## Test plan
- Reset then read: rst=0 for 2 cycles, release. With SA=0, SB=3: A=0, B=0, valid_a=0, valid_b=0.
- Write/read:
  - Write D=4'hA to DA=1, then D=4'h5 to DA=2.
  - Next cycle with SA=1, SB=2: A=4'hA, B=4'h5, both valid=1.
  - Entries 0 and 3 remain 0/invalid.
- Bypass (BYPASS=1, REG_READ=0): with W=1, DA=3, D=4'hC, SA=SB=3, A=B=4'hC and valid=1 in the same cycle. Repeat with BYPASS=0: A=B=0, valid=0 that cycle and 4'hC the next.
- clr priority: entries 1 and 2 hold data. Assert clr=1 with W=1, DA=1, D=4'hF. Next cycle every address reads 0/invalid and wr_err=0.
- Out of range (DEPTH=3): W=1, DA=3, D=4'h7. Next cycle wr_err=1, entries 0–2 are unchanged, and SA=3 reads A=0, valid_a=0.
- Registered read (REG_READ=1): write 4'h9 to DA=0 with SA=0. A=4'h9 one cycle after the edge. Async rst mid-cycle forces A=0 immediately.
